// File: rtl/spi_ram_master.sv
// Purpose: SPI master that runs a two-frame write or read transaction against an external serial RAM.
// Latency: 22 + GAP_CYCLES cycles from accepted start to done (+ MISO_DELAY on reads).
// Backpressure: start is taken only in IDLE or FIN; a start while busy is dropped, never queued.
module spi_ram_master #(
    parameter int GAP_CYCLES = 1,
    parameter int MISO_DELAY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);

    typedef enum logic [2:0] {IDLE, SEL, CMD1, CMD0, WAIT, SHIFT, GAP, FIN} state_t;

    state_t     state, state_nxt;
    logic       op_q;
    logic       frame_b;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [3:0] cnt;
    logic       mosi_nxt;
    logic       ss_n_nxt;
    logic       accept;
    logic       rd_capture;

    assign accept     = start && ((state == IDLE) || (state == FIN));
    assign rd_capture = frame_b && !op_q;
    assign busy       = (state != IDLE) && (state != FIN);
    assign done       = (state == FIN);

    // Command bits: CMD[1] = ~op, CMD[0] = frame B.
    always_comb begin
        state_nxt = state;
        mosi_nxt  = 1'b0;
        ss_n_nxt  = 1'b0;
        case (state)
            IDLE, FIN: begin
                ss_n_nxt  = 1'b1;
                state_nxt = start ? SEL : IDLE;
            end
            SEL: begin
                mosi_nxt  = op_q;
                state_nxt = CMD1;
            end
            CMD1: begin
                mosi_nxt  = ~op_q;
                state_nxt = CMD0;
            end
            CMD0: begin
                mosi_nxt  = frame_b;
                state_nxt = (rd_capture && (MISO_DELAY > 0)) ? WAIT : SHIFT;
            end
            WAIT: begin
                if (int'(cnt) == MISO_DELAY - 1) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!frame_b)  mosi_nxt = addr_q[~bit_cnt];
                else if (op_q) mosi_nxt = wdata_q[~bit_cnt];
                if (bit_cnt == 3'd7) state_nxt = frame_b ? FIN : GAP;
            end
            GAP: begin
                ss_n_nxt = 1'b1;
                if (int'(cnt) == GAP_CYCLES - 1) state_nxt = SEL;
            end
            default: begin
                ss_n_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            frame_b <= 1'b0;
            bit_cnt <= 3'd0;
            cnt     <= 4'd0;
            rdata   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                frame_b <= 1'b0;
            end else if (state == GAP) begin
                frame_b <= 1'b1;
            end
            bit_cnt <= (state == SHIFT) ? bit_cnt + 3'd1 : 3'd0;
            cnt     <= ((state == WAIT || state == GAP) && state_nxt == state) ? cnt + 4'd1 : 4'd0;
            // The last MISO bit lands on the falling edge before this rising edge.
            if (state == SHIFT && bit_cnt == 3'd7 && rd_capture) rdata <= shreg;
        end
    end

    // Pins launch half a period after the FSM so the slave sees stable data on the rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n  <= 1'b1;
            MOSI  <= 1'b0;
            shreg <= 8'h00;
        end else begin
            SS_n <= ss_n_nxt;
            MOSI <= mosi_nxt;
            if (state == SHIFT && rd_capture) shreg <= {shreg[6:0], MISO};
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Randomized bench for spi_ram_master: a serial RAM slave model plus a reference memory and frame model.
module tb_spi_ram_master;
    localparam int GAP       = 1;
    localparam int MD        = 0;
    localparam int FRAME_LEN = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic       miso = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, mosi, ss_n;

    spi_ram_master #(.GAP_CYCLES(GAP), .MISO_DELAY(MD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .MOSI(mosi), .MISO(miso), .SS_n(ss_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]  slave_mem [256];
    logic [7:0]  exp_mem   [256];
    logic [7:0]  last_rd;

    logic [10:0] fbits;
    int          flen = 0;
    int          hi_len = 0;
    logic [2:0]  s_cmd = 3'b000;
    logic [7:0]  s_addr = 8'h00;
    logic [7:0]  s_byte;
    logic [10:0] fr_bits_q [$];
    int          fr_len_q  [$];
    int          gap_q     [$];

    // Slave samples MOSI on the rising edge and presents read data right after CMD[0] arrives.
    always @(posedge clk) begin
        if (!rst_n) begin
            flen   = 0;
            hi_len = 0;
            miso   = 1'b0;
        end else if (!ss_n) begin
            if (flen == 0) gap_q.push_back(hi_len);
            fbits = {fbits[9:0], mosi};
            flen++;
            if (flen == 3) s_cmd = fbits[2:0];
            miso = 1'b0;
            if (flen >= 3 && flen <= 10 && s_cmd[1:0] == 2'b11) begin
                s_byte = slave_mem[s_addr];
                miso   = s_byte[10 - flen];
            end
            if (flen == 11) begin
                if (!s_cmd[0])     s_addr = fbits[7:0];
                else if (!s_cmd[1]) slave_mem[s_addr] = fbits[7:0];
            end
        end else begin
            if (flen != 0) begin
                fr_bits_q.push_back(fbits);
                fr_len_q.push_back(flen);
                flen   = 0;
                hi_len = 0;
            end
            hi_len++;
            miso = 1'b0;
        end
    end

    function automatic logic [10:0] exp_frame(input logic o, input logic b, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] payload;
        payload = b ? (o ? d : 8'h00) : a;
        return {o, ~o, b, payload};
    endfunction

    task automatic check_frames(input logic t_op, input logic [7:0] t_addr, input logic [7:0] t_dat, input int gap_a);
        int ga;
        chk("frame_count", 32'(fr_bits_q.size() >= 2 && gap_q.size() >= 2), 1);
        if (fr_bits_q.size() < 2 || gap_q.size() < 2) return;
        chk("frameA_mosi", 32'(fr_bits_q.pop_front()), 32'(exp_frame(t_op, 1'b0, t_addr, t_dat)));
        chk("frameA_len", fr_len_q.pop_front(), FRAME_LEN);
        ga = gap_q.pop_front();
        if (gap_a >= 0) chk("gap_before_A", ga, gap_a);
        chk("frameB_mosi", 32'(fr_bits_q.pop_front()), 32'(exp_frame(t_op, 1'b1, t_addr, t_dat)));
        chk("frameB_len", fr_len_q.pop_front(), FRAME_LEN + (t_op ? 0 : MD));
        chk("gap_A_B", gap_q.pop_front(), GAP);
    endtask

    // Called on a falling edge; returns on the falling edge where done is seen.
    task automatic do_txn(input logic t_op, input logic [7:0] t_addr, input logic [7:0] t_dat, input int inject_at);
        int n;
        op = t_op; addr = t_addr; wdata = t_dat; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        addr  = 8'($urandom);
        wdata = 8'($urandom);
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == inject_at);
        end
        chk("latency", n, 22 + GAP + (t_op ? 0 : MD));
        if (t_op) exp_mem[t_addr] = t_dat;
        else      last_rd = exp_mem[t_addr];
        chk("rdata", rdata, last_rd);
        chk("busy_in_fin", busy, 0);
    endtask

    task automatic txn(input logic t_op, input logic [7:0] t_addr, input logic [7:0] t_dat);
        do_txn(t_op, t_addr, t_dat, -1);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        check_frames(t_op, t_addr, t_dat, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        logic       r_op;
        logic [7:0] r_addr, r_dat;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'(i) ^ 8'hA5;
            exp_mem[i]   = 8'(i) ^ 8'hA5;
        end
        last_rd = 8'h00;

        #12;
        chk("rst_ss_n", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);

        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b1, 8'd100, 8'd11);
        txn(1'b0, 8'd100, 8'h00);
        chk("read_0x0b", rdata, 8'h0B);

        for (int i = 0; i < 100; i++) txn(1'b1, 8'(100 + i), 8'(11 * ((i % 23) + 1)));
        for (int i = 0; i < 100; i++) txn(1'b0, 8'(100 + i), 8'h00);

        for (int i = 0; i < 40; i++) begin
            r_op   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            case ($urandom_range(0, 3))
                0:       r_dat = 8'h00;
                1:       r_dat = 8'hFF;
                default: r_dat = 8'($urandom);
            endcase
            txn(r_op, r_addr, r_dat);
        end

        // start pulsed while busy must be dropped
        do_txn(1'b1, 8'h37, 8'hC3, 5);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (done) extra++;
        end
        chk("no_queued_done", extra, 0);
        chk("ss_low_pulses", fr_bits_q.size(), 2);
        check_frames(1'b1, 8'h37, 8'hC3, -1);

        // back-to-back: second start lands in FIN
        do_txn(1'b1, 8'h10, 8'h5A, -1);
        do_txn(1'b0, 8'h10, 8'h00, -1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done_low", done, 0);
        check_frames(1'b1, 8'h10, 8'h5A, -1);
        check_frames(1'b0, 8'h10, 8'h00, 1);

        // reset during frame B SHIFT bit 4 of a read
        op = 1'b0; addr = 8'h20; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("ss_low_before_rst", ss_n, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", ss_n, 1);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rdata", rdata, 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("midrst_no_done", extra, 0);
        rst_n = 1'b1;
        fr_bits_q.delete();
        fr_len_q.delete();
        gap_q.delete();
        last_rd = 8'h00;
        txn(1'b0, 8'h20, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
